// File: rtl/m_rect_fill.sv
// Rectangle fill/outline rasteriser: scans a latched rectangle one pixel per cycle into video memory.
// Optional corner clamping to MAX_COORD is enabled with the RECT_FILL_CLIP_EN macro.
module m_rect_fill #(
    parameter int unsigned MAX_COORD = 239
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [7:0]  i_x0,
    input  logic [7:0]  i_y0,
    input  logic [7:0]  i_x1,
    input  logic [7:0]  i_y1,
    input  logic [15:0] i_color,
    input  logic        i_outline,
    input  logic        i_hold,
    output logic        o_we,
    output logic [15:0] o_wadr,
    output logic [15:0] o_wdata,
    output logic        o_done
);

    typedef enum logic {StIdle, StScan} state_e;

    if (MAX_COORD > 255) begin : g_max_coord_chk
        $error("MAX_COORD must fit in 8 bits");
    end

    state_e      state_q, state_d;
    logic [7:0]  xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [7:0]  cx_q, cx_d, cy_q, cy_d;
    logic [15:0] color_q, color_d;
    logic        mode_q, mode_d;
    logic        we_q, we_d, done_q, done_d;
    logic [15:0] wadr_q, wadr_d, wdata_q, wdata_d;

    logic [7:0]  x0_c, y0_c, x1_c, y1_c;
    logic        border, pix_we;

`ifdef RECT_FILL_CLIP_EN
    localparam logic [7:0] MaxC = 8'(MAX_COORD);

    function automatic logic [7:0] clamp(input logic [7:0] v);
        return (v > MaxC) ? MaxC : v;
    endfunction

    assign x0_c = clamp(i_x0);
    assign y0_c = clamp(i_y0);
    assign x1_c = clamp(i_x1);
    assign y1_c = clamp(i_y1);
`else
    assign x0_c = i_x0;
    assign y0_c = i_y0;
    assign x1_c = i_x1;
    assign y1_c = i_y1;
`endif

    assign border = (cx_q == xmin_q) || (cx_q == xmax_q) || (cy_q == ymin_q) || (cy_q == ymax_q);
    assign pix_we = !mode_q || border;

    always_comb begin
        state_d = state_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        color_d = color_q;
        mode_d  = mode_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        wadr_d  = wadr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    xmin_d  = (x0_c < x1_c) ? x0_c : x1_c;
                    xmax_d  = (x0_c < x1_c) ? x1_c : x0_c;
                    ymin_d  = (y0_c < y1_c) ? y0_c : y1_c;
                    ymax_d  = (y0_c < y1_c) ? y1_c : y0_c;
                    cx_d    = xmin_d;
                    cy_d    = ymin_d;
                    color_d = i_color;
                    mode_d  = i_outline;
                    state_d = StScan;
                end
            end
            StScan: begin
                // Hold freezes the cursor; the pixel is revisited once hold drops.
                if (!i_hold) begin
                    we_d = pix_we;
                    if (pix_we) begin
                        wadr_d  = {cy_q, cx_q};
                        wdata_d = color_q;
                    end
                    if (cx_q == xmax_q) begin
                        cx_d = xmin_q;
                        if (cy_q == ymax_q) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            cy_d = cy_q + 8'd1;
                        end
                    end else begin
                        cx_d = cx_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= StIdle;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            color_q <= '0;
            mode_q  <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            wadr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            color_q <= color_d;
            mode_q  <= mode_d;
            we_q    <= we_d;
            done_q  <= done_d;
            wadr_q  <= wadr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_ready = (state_q == StIdle);
    assign o_we    = we_q;
    assign o_done  = done_q;
    assign o_wadr  = wadr_q;
    assign o_wdata = wdata_q;

endmodule

// File: tb/tb_m_rect_fill.sv
// Directed bench for m_rect_fill: command table with hand-counted writes/cycles, a raster
// reference for addresses, plus hand-written reset sequences.
module tb_m_rect_fill;

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [7:0]  i_x0 = '0, i_y0 = '0, i_x1 = '0, i_y1 = '0;
    logic [15:0] i_color = '0;
    logic        i_outline = 1'b0;
    logic        i_hold = 1'b0;
    logic        o_we;
    logic [15:0] o_wadr, o_wdata;
    logic        o_done;

    m_rect_fill dut (
        .w_clk    (w_clk),
        .w_rst_n  (w_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_x0     (i_x0),
        .i_y0     (i_y0),
        .i_x1     (i_x1),
        .i_y1     (i_y1),
        .i_color  (i_color),
        .i_outline(i_outline),
        .i_hold   (i_hold),
        .o_we     (o_we),
        .o_wadr   (o_wadr),
        .o_wdata  (o_wdata),
        .o_done   (o_done)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        logic [7:0]  x0, y0, x1, y1;
        logic [15:0] col;
        logic        ol;
        int          hold_len;
        int          exp_cnt;
        int          exp_scan;
    } vec_t;

    localparam int NVec = 8;
    vec_t vecs[NVec];

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] got_adr[$], got_dat[$], exp_adr[$];
    logic [15:0] last_adr = '0, last_dat = '0;
    int done_cnt, done_idx, nscan;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] clipc(input logic [7:0] v);
`ifdef RECT_FILL_CLIP_EN
        return (v > 8'd239) ? 8'd239 : v;
`else
        return v;
`endif
    endfunction

    // Reference raster order, independent of the DUT's cursor logic.
    task automatic build_exp(input vec_t v);
        int xa, xb, ya, yb;
        xa = int'(clipc(v.x0)); xb = int'(clipc(v.x1));
        ya = int'(clipc(v.y0)); yb = int'(clipc(v.y1));
        if (xa > xb) begin int t = xa; xa = xb; xb = t; end
        if (ya > yb) begin int t = ya; ya = yb; yb = t; end
        exp_adr.delete();
        for (int y = ya; y <= yb; y++)
            for (int x = xa; x <= xb; x++)
                if (!v.ol || x == xa || x == xb || y == ya || y == yb)
                    exp_adr.push_back({y[7:0], x[7:0]});
    endtask

    // Sample once per negedge after issuing the command until o_ready returns.
    task automatic run_cmd(input vec_t v);
        int hold_left;
        bit hold_started;
        hold_left = 0;
        hold_started = 0;
        got_adr.delete();
        got_dat.delete();
        done_cnt = 0;
        done_idx = -1;
        nscan = 0;
        @(negedge w_clk);
        check("ready_before_cmd", 32'(o_ready), 32'd1);
        i_x0 = v.x0; i_y0 = v.y0; i_x1 = v.x1; i_y1 = v.y1;
        i_color = v.col; i_outline = v.ol; i_valid = 1'b1;
        forever begin
            @(negedge w_clk);
            i_valid = 1'b0;
            if (o_we) begin
                got_adr.push_back(o_wadr);
                got_dat.push_back(o_wdata);
                last_adr = o_wadr;
                last_dat = o_wdata;
            end else begin
                check("hold_adr_no_we", 32'(o_wadr), 32'(last_adr));
                check("hold_dat_no_we", 32'(o_wdata), 32'(last_dat));
            end
            if (o_done) begin
                done_cnt++;
                done_idx = got_adr.size();
                check("done_with_we", 32'(o_we), 32'd1);
                check("done_with_ready", 32'(o_ready), 32'd1);
            end
            if (o_ready) break;
            nscan++;
            if (nscan > 70000) begin
                check("scan_timeout", 32'(nscan), 32'd0);
                break;
            end
            if (!hold_started && v.hold_len > 0 && got_adr.size() == 1) begin
                hold_started = 1;
                hold_left = v.hold_len;
            end
            if (hold_left > 0) begin
                i_hold = 1'b1;
                hold_left--;
            end else begin
                i_hold = 1'b0;
            end
        end
        i_hold = 1'b0;
    endtask

    task automatic run_and_check(input vec_t v);
        build_exp(v);
        run_cmd(v);
        check("write_count", 32'(got_adr.size()), 32'(v.exp_cnt));
        check("model_count", 32'(exp_adr.size()), 32'(v.exp_cnt));
        check("scan_cycles", 32'(nscan), 32'(v.exp_scan));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("done_on_last", 32'(done_idx), 32'(got_adr.size()));
        for (int i = 0; i < got_adr.size() && i < exp_adr.size(); i++) begin
            check("wadr", 32'(got_adr[i]), 32'(exp_adr[i]));
            check("wdata", 32'(got_dat[i]), 32'(v.col));
        end
    endtask

    initial begin
        // x0 y0 x1 y1 col outline hold exp_cnt exp_scan
        vecs[0] = '{8'd10, 8'd20, 8'd12, 8'd21, 16'hF800, 1'b0, 0, 6, 6};
        vecs[1] = '{8'd12, 8'd21, 8'd10, 8'd20, 16'hF800, 1'b0, 0, 6, 6};
        vecs[2] = '{8'd0, 8'd0, 8'd3, 8'd3, 16'h07E0, 1'b1, 0, 12, 16};
        vecs[3] = '{8'd5, 8'd5, 8'd7, 8'd5, 16'h001F, 1'b0, 2, 3, 5};
        vecs[4] = '{8'd9, 8'd9, 8'd9, 8'd9, 16'h1234, 1'b0, 0, 1, 1};
        vecs[5] = '{8'd3, 8'd7, 8'd3, 8'd2, 16'hABCD, 1'b0, 0, 6, 6};
        vecs[6] = '{8'd4, 8'd1, 8'd1, 8'd1, 16'h5555, 1'b1, 0, 4, 4};
`ifdef RECT_FILL_CLIP_EN
        vecs[7] = '{8'd238, 8'd238, 8'd250, 8'd250, 16'hFFFF, 1'b0, 0, 4, 4};
`else
        vecs[7] = '{8'd238, 8'd238, 8'd250, 8'd250, 16'hFFFF, 1'b0, 0, 169, 169};
`endif

        #2;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_we", 32'(o_we), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_wadr", 32'(o_wadr), 32'd0);
        check("rst_wdata", 32'(o_wdata), 32'd0);
        @(negedge w_clk);
        w_rst_n = 1'b1;

        for (int k = 0; k < NVec; k++) run_and_check(vecs[k]);

        // Outline interior must never be written.
        build_exp(vecs[2]);
        run_cmd(vecs[2]);
        begin
            int bad;
            bad = 0;
            foreach (got_adr[i])
                if (got_adr[i] == 16'h0101 || got_adr[i] == 16'h0102 ||
                    got_adr[i] == 16'h0201 || got_adr[i] == 16'h0202) bad++;
            check("outline_interior_writes", 32'(bad), 32'd0);
        end

        // Reset mid-scan on a large fill, at the 100th write.
        @(negedge w_clk);
        i_x0 = 8'd0; i_y0 = 8'd0; i_x1 = 8'd239; i_y1 = 8'd239;
        i_color = 16'hCAFE; i_outline = 1'b0; i_valid = 1'b1;
        @(negedge w_clk);
        i_valid = 1'b0;
        begin
            int nw, cyc;
            nw = 0;
            cyc = 0;
            while (nw < 100 && cyc < 1000) begin
                if (o_we) nw++;
                if (nw < 100) begin
                    @(negedge w_clk);
                    cyc++;
                end
            end
            check("reached_write_100", 32'(nw), 32'd100);
        end
        w_rst_n = 1'b0;
        #1;
        check("abort_we", 32'(o_we), 32'd0);
        check("abort_ready", 32'(o_ready), 32'd1);
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_wadr", 32'(o_wadr), 32'd0);
        repeat (2) begin
            @(negedge w_clk);
            check("abort_no_we", 32'(o_we), 32'd0);
            check("abort_no_done", 32'(o_done), 32'd0);
        end
        w_rst_n = 1'b1;
        last_adr = '0;
        last_dat = '0;
        run_and_check(vecs[4]);
        check("post_reset_adr", 32'(got_adr.size() > 0 ? got_adr[0] : 16'h0), 32'h0909);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
